// File: rtl/writeback_commit_pkg.sv
// rtl/writeback_commit_pkg.sv - shared types for the multi-lane writeback/commit stage
package writeback_commit_pkg;

    typedef logic [11:0] destinationCSR_;

    typedef enum logic [1:0] {
        CSR_NONE = 2'd0,
        CSR_RW   = 2'd1,
        CSR_RS   = 2'd2,
        CSR_RC   = 2'd3
    } csrOp_;

    typedef struct packed {
        logic           valid;
        logic           illegal;
        logic           writebackEnable;
        logic [4:0]     destinationRegister;
        logic [31:0]    data;
        csrOp_          CSROp;
        destinationCSR_ destinationCSR;
        logic [31:0]    oldCSRValue;
        logic           CSRWriteIntent;
    } memoryWritebackPayload_;

    typedef struct packed {
        destinationCSR_ csr;
        logic [31:0]    data;
    } csrWriteEntry_;

endpackage

// File: rtl/writeback_commit_csr_write_fifo.sv
// rtl/writeback_commit_csr_write_fifo.sv - in-order CSR write queue, up to LANES pushes and one pop per cycle
module csr_write_fifo
    import writeback_commit_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int LANES = 2
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [LANES-1:0]             push_valid,
    input  csrWriteEntry_ [LANES-1:0]    push_entry,
    input  logic                         pop_ready,
    output csrWriteEntry_                head_entry,
    output logic                         head_valid,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    csrWriteEntry_           r_mem [DEPTH];
    logic [PTR_W-1:0]        r_wr_ptr;
    logic [PTR_W-1:0]        r_rd_ptr;
    logic [CNT_W-1:0]        r_count;
    logic [PTR_W-1:0]        w_slot [LANES];
    logic [CNT_W-1:0]        w_push_num;
    logic [PTR_W-1:0]        w_wr_ptr_next;
    logic                    w_pop;

    // Compact pushing lanes into consecutive slots, oldest lane first
    always_comb begin
        int ofs;
        ofs = 0;
        for (int l = 0; l < LANES; l++) begin
            w_slot[l] = PTR_W'((int'(r_wr_ptr) + ofs) % DEPTH);
            if (push_valid[l]) begin
                ofs = ofs + 1;
            end
        end
        w_push_num    = CNT_W'(ofs);
        w_wr_ptr_next = PTR_W'((int'(r_wr_ptr) + ofs) % DEPTH);
    end

    assign head_valid = (r_count != '0);
    assign w_pop      = pop_ready & head_valid;
    assign head_entry = head_valid ? r_mem[r_rd_ptr] : '0;
    assign count      = r_count;

    // Entry storage; no reset needed because the head is masked while empty
    always_ff @(posedge clock) begin
        for (int l = 0; l < LANES; l++) begin
            if (push_valid[l]) begin
                r_mem[w_slot[l]] <= push_entry[l];
            end
        end
    end

    // Pointer and occupancy bookkeeping; push and pop may coincide
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= w_wr_ptr_next;
            if (w_pop) begin
                r_rd_ptr <= PTR_W'((int'(r_rd_ptr) + 1) % DEPTH);
            end
            r_count <= r_count + w_push_num - CNT_W'(w_pop);
        end
    end

endmodule

// File: rtl/writeback_commit.sv
// rtl/writeback_commit.sv - multi-lane writeback/commit stage; WRITEBACK_RETIRE_COUNTER_EN adds retireCount
module writeback_commit
    import writeback_commit_pkg::*;
#(
    parameter int LANES           = 2,
    parameter int CSR_QUEUE_DEPTH = 4,
    parameter int RETIRE_WIDTH    = 64
) (
    input  logic                            clock,
    input  logic                            reset,
    input  memoryWritebackPayload_ [LANES-1:0] memoryWritebackPayload,
    input  logic                            interrupt,
    output logic                            writebackStall,
    output logic [LANES-1:0]                destinationEnable,
    output logic [LANES-1:0][4:0]           writeAddress,
    output logic [LANES-1:0][31:0]          writeData,
    output logic [LANES-1:0]                memoryWritebackValid,
    output destinationCSR_                  destinationCSR,
    output logic [31:0]                     csrWriteData,
    output logic                            csrDestinationEnable,
    input  logic                            csrReady,
    output logic                            interruptTake
`ifdef WRITEBACK_RETIRE_COUNTER_EN
    ,
    output logic [RETIRE_WIDTH-1:0]         retireCount
`endif
);

    localparam int CNT_W = $clog2(CSR_QUEUE_DEPTH + 1);
    localparam logic [CNT_W-1:0] STALL_ABOVE = CNT_W'(CSR_QUEUE_DEPTH - LANES);

    logic [LANES-1:0]           w_retire;
    logic [LANES-1:0]           w_push;
    csrWriteEntry_ [LANES-1:0]  w_push_entry;
    csrWriteEntry_              w_head;
    logic [CNT_W-1:0]           w_count;
    logic                       r_pending;
    logic                       r_take;

    // Stall whenever a full-width retire could overflow the queue
    assign writebackStall = (w_count > STALL_ABOVE);

    // Per-lane retire qualification, register-file write port and CSR push request
    always_comb begin
        destinationEnable    = '0;
        writeAddress         = '0;
        writeData            = '0;
        memoryWritebackValid = '0;
        w_retire             = '0;
        w_push               = '0;
        w_push_entry         = '0;
        for (int l = 0; l < LANES; l++) begin
            w_retire[l]             = memoryWritebackPayload[l].valid & ~memoryWritebackPayload[l].illegal
                                      & ~writebackStall;
            memoryWritebackValid[l] = memoryWritebackPayload[l].valid;
            writeAddress[l]         = memoryWritebackPayload[l].destinationRegister;
            if (memoryWritebackPayload[l].CSROp != CSR_NONE) begin
                destinationEnable[l] = w_retire[l];
                writeData[l]         = memoryWritebackPayload[l].oldCSRValue;
                w_push[l]            = w_retire[l] & memoryWritebackPayload[l].CSRWriteIntent;
            end else begin
                destinationEnable[l] = w_retire[l] & memoryWritebackPayload[l].writebackEnable;
                writeData[l]         = memoryWritebackPayload[l].data;
            end
            w_push_entry[l].csr  = memoryWritebackPayload[l].destinationCSR;
            w_push_entry[l].data = memoryWritebackPayload[l].data;
        end
    end

    csr_write_fifo #(
        .DEPTH (CSR_QUEUE_DEPTH),
        .LANES (LANES)
    ) u_csr_write_fifo (
        .clock      (clock),
        .reset      (reset),
        .push_valid (w_push),
        .push_entry (w_push_entry),
        .pop_ready  (csrReady),
        .head_entry (w_head),
        .head_valid (csrDestinationEnable),
        .count      (w_count)
    );

    assign destinationCSR = w_head.csr;
    assign csrWriteData   = w_head.data;
    assign interruptTake  = r_take;

    // Hold the interrupt until some instruction retires, then pulse take; a new request re-arms
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pending <= 1'b0;
            r_take    <= 1'b0;
        end else begin
            r_take    <= r_pending & (|w_retire);
            r_pending <= interrupt | (r_pending & ~(|w_retire));
        end
    end

`ifdef WRITEBACK_RETIRE_COUNTER_EN
    logic [RETIRE_WIDTH-1:0] w_retire_num;
    logic [RETIRE_WIDTH-1:0] r_retire_count;

    // Number of lanes retiring this cycle
    always_comb begin
        w_retire_num = '0;
        for (int l = 0; l < LANES; l++) begin
            w_retire_num = w_retire_num + RETIRE_WIDTH'(w_retire[l]);
        end
    end

    // Free-running retire counter, wraps naturally
    always_ff @(posedge clock) begin
        if (reset) begin
            r_retire_count <= '0;
        end else begin
            r_retire_count <= r_retire_count + w_retire_num;
        end
    end

    assign retireCount = r_retire_count;
`else
    logic unused_retire_width;
    assign unused_retire_width = ^RETIRE_WIDTH;
`endif

endmodule

// File: tb/tb_writeback_commit.sv
// tb/tb_writeback_commit.sv - scoreboard bench for writeback_commit (LANES=2, depth 4)
module tb_writeback_commit;
    import writeback_commit_pkg::*;

    localparam int LANES = 2;
    localparam int DEPTH = 4;
    localparam int RW    = 64;

    logic                          clock = 1'b0;
    logic                          reset;
    memoryWritebackPayload_ [LANES-1:0] memoryWritebackPayload;
    logic                          interrupt;
    logic                          writebackStall;
    logic [LANES-1:0]              destinationEnable;
    logic [LANES-1:0][4:0]         writeAddress;
    logic [LANES-1:0][31:0]        writeData;
    logic [LANES-1:0]              memoryWritebackValid;
    destinationCSR_                destinationCSR;
    logic [31:0]                   csrWriteData;
    logic                          csrDestinationEnable;
    logic                          csrReady;
    logic                          interruptTake;
`ifdef WRITEBACK_RETIRE_COUNTER_EN
    logic [RW-1:0]                 retireCount;
`endif

    writeback_commit #(
        .LANES           (LANES),
        .CSR_QUEUE_DEPTH (DEPTH),
        .RETIRE_WIDTH    (RW)
    ) dut (
        .clock                  (clock),
        .reset                  (reset),
        .memoryWritebackPayload (memoryWritebackPayload),
        .interrupt              (interrupt),
        .writebackStall         (writebackStall),
        .destinationEnable      (destinationEnable),
        .writeAddress           (writeAddress),
        .writeData              (writeData),
        .memoryWritebackValid   (memoryWritebackValid),
        .destinationCSR         (destinationCSR),
        .csrWriteData           (csrWriteData),
        .csrDestinationEnable   (csrDestinationEnable),
        .csrReady               (csrReady),
        .interruptTake          (interruptTake)
`ifdef WRITEBACK_RETIRE_COUNTER_EN
        ,
        .retireCount            (retireCount)
`endif
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;
    csrWriteEntry_ exp_q[$];
    memoryWritebackPayload_ idle_p;
    logic [RW-1:0] exp_rc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h expected=%h", name, act, exp);
    endtask

    function automatic memoryWritebackPayload_ mk(input logic v, input logic ill, input logic wbe,
                                                  input logic [4:0] rd, input logic [31:0] d,
                                                  input csrOp_ op, input destinationCSR_ c,
                                                  input logic [31:0] old, input logic intent);
        memoryWritebackPayload_ p;
        p.valid = v; p.illegal = ill; p.writebackEnable = wbe; p.destinationRegister = rd;
        p.data = d; p.CSROp = op; p.destinationCSR = c; p.oldCSRValue = old; p.CSRWriteIntent = intent;
        return p;
    endfunction

    task automatic drive(input memoryWritebackPayload_ p0, input memoryWritebackPayload_ p1);
        memoryWritebackPayload[0] = p0;
        memoryWritebackPayload[1] = p1;
    endtask

    task automatic push_exp(input destinationCSR_ c, input logic [31:0] d);
        csrWriteEntry_ e;
        e.csr = c; e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Monitor: every accepted CSR write must match the oldest expected entry
    always @(negedge clock) begin
        if (!reset && csrDestinationEnable && csrReady) begin
            if (exp_q.size() == 0) begin
                chk("csr_unexpected_pop", {52'd0, destinationCSR}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                csrWriteEntry_ e;
                e = exp_q.pop_front();
                chk("csr_addr", {52'd0, destinationCSR}, {52'd0, e.csr});
                chk("csr_data", {32'd0, csrWriteData}, {32'd0, e.data});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        idle_p    = '0;
        exp_rc    = '0;
        reset     = 1'b1;
        interrupt = 1'b0;
        csrReady  = 1'b0;
        drive(idle_p, idle_p);
        tick; tick;
        reset = 1'b0;

        // reset state
        @(negedge clock);
        chk("rst_csr_en", {63'd0, csrDestinationEnable}, 64'd0);
        chk("rst_csr_addr", {52'd0, destinationCSR}, 64'd0);
        chk("rst_csr_data", {32'd0, csrWriteData}, 64'd0);
        chk("rst_stall", {63'd0, writebackStall}, 64'd0);
        chk("rst_take", {63'd0, interruptTake}, 64'd0);
`ifdef WRITEBACK_RETIRE_COUNTER_EN
        chk("rst_retire_count", retireCount, 64'd0);
`endif
        tick;

        // ALU write on lane 0, lane 1 valid without writeback
        drive(mk(1, 0, 1, 5'd5, 32'h1234, CSR_NONE, 12'h0, 32'h0, 0),
              mk(1, 0, 0, 5'd6, 32'h9, CSR_NONE, 12'h0, 32'h0, 0));
        @(negedge clock);
        chk("alu_en", {62'd0, destinationEnable}, 64'h1);
        chk("alu_addr0", {59'd0, writeAddress[0]}, 64'd5);
        chk("alu_data0", {32'd0, writeData[0]}, 64'h1234);
        chk("alu_valid_pass", {62'd0, memoryWritebackValid}, 64'h3);
        exp_rc += 2;
        tick;

        // CSRRW: x-reg gets old value, CSR write appears next cycle
        csrReady = 1'b1;
        drive(mk(1, 0, 0, 5'd7, 32'h55, CSR_RW, 12'h300, 32'hAA, 1), idle_p);
        push_exp(12'h300, 32'h55);
        @(negedge clock);
        chk("csrrw_en", {62'd0, destinationEnable}, 64'h1);
        chk("csrrw_xdata", {32'd0, writeData[0]}, 64'hAA);
        chk("csrrw_no_head_yet", {63'd0, csrDestinationEnable}, 64'd0);
        exp_rc += 1;
        tick;
        drive(idle_p, idle_p);
        @(negedge clock);
        chk("csrrw_head_next", {63'd0, csrDestinationEnable}, 64'd1);
        tick;
        @(negedge clock);
        chk("csrrw_drained", {63'd0, csrDestinationEnable}, 64'd0);
        tick;

        // Fill the queue with csrReady low, then check stall and ordered drain
        csrReady = 1'b0;
        drive(mk(1, 0, 0, 5'd8, 32'h11, CSR_RW, 12'h301, 32'h1001, 1),
              mk(1, 0, 0, 5'd9, 32'h22, CSR_RW, 12'h302, 32'h1002, 1));
        push_exp(12'h301, 32'h11);
        push_exp(12'h302, 32'h22);
        @(negedge clock);
        chk("fill1_en", {62'd0, destinationEnable}, 64'h3);
        chk("fill1_xdata1", {32'd0, writeData[1]}, 64'h1002);
        chk("fill1_stall", {63'd0, writebackStall}, 64'd0);
        exp_rc += 2;
        tick;
        drive(mk(1, 0, 0, 5'd10, 32'h33, CSR_RS, 12'h303, 32'h1003, 1),
              mk(1, 0, 0, 5'd11, 32'h44, CSR_RC, 12'h304, 32'h1004, 1));
        push_exp(12'h303, 32'h33);
        push_exp(12'h304, 32'h44);
        @(negedge clock);
        chk("fill2_stall", {63'd0, writebackStall}, 64'd0);
        chk("fill2_en", {62'd0, destinationEnable}, 64'h3);
        exp_rc += 2;
        tick;
        drive(mk(1, 0, 0, 5'd12, 32'h66, CSR_RW, 12'h305, 32'h1005, 1),
              mk(1, 0, 1, 5'd13, 32'h77, CSR_NONE, 12'h0, 32'h0, 0));
        @(negedge clock);
        chk("full_stall", {63'd0, writebackStall}, 64'd1);
        chk("full_no_en", {62'd0, destinationEnable}, 64'd0);
        tick;
        drive(idle_p, idle_p);
        csrReady = 1'b1;
        repeat (5) tick;
        @(negedge clock);
        chk("drain_empty", {63'd0, csrDestinationEnable}, 64'd0);
        chk("drain_stall", {63'd0, writebackStall}, 64'd0);
        chk("drain_sb_empty", 64'(exp_q.size()), 64'd0);
        tick;

        // CSR op without write intent plus an illegal CSR lane
        drive(mk(1, 0, 0, 5'd14, 32'h0, CSR_RS, 12'h340, 32'hBB, 0),
              mk(1, 1, 1, 5'd15, 32'h88, CSR_RW, 12'h341, 32'hCC, 1));
        @(negedge clock);
        chk("illegal_en", {62'd0, destinationEnable}, 64'h1);
        chk("illegal_xdata0", {32'd0, writeData[0]}, 64'hBB);
        exp_rc += 1;
        tick;
        drive(idle_p, idle_p);
        @(negedge clock);
        chk("illegal_no_push", {63'd0, csrDestinationEnable}, 64'd0);
        tick;

        // Interrupt held across three idle cycles, taken after one retire
        interrupt = 1'b1;
        @(negedge clock);
        chk("irq_idle0", {63'd0, interruptTake}, 64'd0);
        tick;
        interrupt = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            chk("irq_idle", {63'd0, interruptTake}, 64'd0);
            tick;
        end
        drive(mk(1, 0, 1, 5'd3, 32'h5, CSR_NONE, 12'h0, 32'h0, 0), idle_p);
        @(negedge clock);
        chk("irq_retire_cycle", {63'd0, interruptTake}, 64'd0);
        exp_rc += 1;
        tick;
        drive(idle_p, idle_p);
        @(negedge clock);
        chk("irq_take", {63'd0, interruptTake}, 64'd1);
        tick;
        drive(mk(1, 0, 1, 5'd3, 32'h6, CSR_NONE, 12'h0, 32'h0, 0), idle_p);
        @(negedge clock);
        chk("irq_take_once", {63'd0, interruptTake}, 64'd0);
        exp_rc += 1;
        tick;
        drive(idle_p, idle_p);
        @(negedge clock);
        chk("irq_no_retake", {63'd0, interruptTake}, 64'd0);
`ifdef WRITEBACK_RETIRE_COUNTER_EN
        chk("retire_count", retireCount, exp_rc);
`endif
        tick;

        // Reset with three queued entries discards them
        csrReady = 1'b0;
        drive(mk(1, 0, 0, 5'd1, 32'hA1, CSR_RW, 12'h310, 32'h0, 1),
              mk(1, 0, 0, 5'd2, 32'hA2, CSR_RW, 12'h311, 32'h0, 1));
        tick;
        drive(mk(1, 0, 0, 5'd1, 32'hA3, CSR_RW, 12'h312, 32'h0, 1), idle_p);
        tick;
        drive(idle_p, idle_p);
        @(negedge clock);
        chk("pre_rst_head", {63'd0, csrDestinationEnable}, 64'd1);
        chk("pre_rst_stall", {63'd0, writebackStall}, 64'd1);
        tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        @(negedge clock);
        chk("mid_rst_csr_en", {63'd0, csrDestinationEnable}, 64'd0);
        chk("mid_rst_csr_data", {32'd0, csrWriteData}, 64'd0);
        chk("mid_rst_stall", {63'd0, writebackStall}, 64'd0);
`ifdef WRITEBACK_RETIRE_COUNTER_EN
        chk("mid_rst_retire_count", retireCount, 64'd0);
`endif
        tick;
        csrReady = 1'b1;
        repeat (3) tick;
        @(negedge clock);
        chk("final_sb_empty", 64'(exp_q.size()), 64'd0);
        chk("final_csr_en", {63'd0, csrDestinationEnable}, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
